// File: rtl/window_fetch_ctrl.sv
// Fetches one frame word-by-word from memory and unpacks each word into pixels for the window line buffers.
// Optional read-timeout watchdog enabled by defining WAIT_TIMEOUT_EN.
module window_fetch_ctrl #(
   parameter int          W          = 8,
   parameter int          L          = 80,
   parameter int          ROWS       = 16,
   parameter int          FRAME_ROWS = 150,
   parameter logic [20:0] BASE_ADDR  = 21'd0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [31:0]   user_rd_data,
   input  logic          rd_valid,
   output logic          req,
   output logic          rd_wr,
   output logic [20:0]   user_req_addr,
   output logic          buf_we,
   output logic [W-1:0]  buf_data,
   output logic          window_valid,
   output logic          busy,
   output logic          frame_done,
   output logic          err
);

   localparam int CW = (L > 1) ? $clog2(L) : 1;
   localparam int RW = $clog2(FRAME_ROWS + 1);
   localparam logic [CW-1:0] COL_LAST = CW'(L - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_ROWS - 1);
   localparam logic [RW-1:0] WIN_ROW  = RW'(ROWS - 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, UNPACK, DONE} state_t;

   state_t        state;
   logic [31:0]   word_q;
   logic [1:0]    byte_idx;
   logic [1:0]    nxt_idx;
   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;
   logic          last_word;
   logic          emit;
   logic [W-1:0]  pix;
`ifdef WAIT_TIMEOUT_EN
   logic [7:0]    tmo_cnt;
`endif

   // byte_idx names the byte currently on buf_data; the byte after it is emitted next
   assign nxt_idx = byte_idx + 2'd1;
   assign emit    = (state == WAIT_DATA && rd_valid) || (state == UNPACK && byte_idx != 2'd3);
   assign pix     = (state == WAIT_DATA) ? user_rd_data[W-1:0] : word_q[32'(nxt_idx)*W +: W];

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         word_q        <= '0;
         byte_idx      <= '0;
         col_cnt       <= '0;
         row_cnt       <= '0;
         last_word     <= 1'b0;
         req           <= 1'b0;
         rd_wr         <= 1'b0;
         user_req_addr <= BASE_ADDR;
         buf_we        <= 1'b0;
         buf_data      <= '0;
         window_valid  <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         err           <= 1'b0;
`ifdef WAIT_TIMEOUT_EN
         tmo_cnt       <= '0;
`endif
      end else begin
         req          <= 1'b0;
         rd_wr        <= 1'b0;
         frame_done   <= 1'b0;
         buf_we       <= 1'b0;
         window_valid <= 1'b0;
         if (emit) begin
            buf_we       <= 1'b1;
            buf_data     <= pix;
            window_valid <= (row_cnt >= WIN_ROW);
            if (col_cnt == COL_LAST) begin
               col_cnt <= '0;
               row_cnt <= row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end
         case (state)
            IDLE: if (start) begin
               state <= REQ;
               req   <= 1'b1;
               busy  <= 1'b1;
            end
            REQ: begin
               state <= WAIT_DATA;
`ifdef WAIT_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT_DATA: begin
               if (rd_valid) begin
                  word_q   <= user_rd_data;
                  byte_idx <= 2'd0;
                  state    <= UNPACK;
               end
`ifdef WAIT_TIMEOUT_EN
               else if (tmo_cnt == 8'd254) begin
                  err           <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
                  col_cnt       <= '0;
                  row_cnt       <= '0;
                  user_req_addr <= BASE_ADDR;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            UNPACK: begin
               // decide frame end while byte 3 is emitted, using its pre-increment position
               if (byte_idx == 2'd2 && row_cnt == ROW_LAST && col_cnt == COL_LAST)
                  last_word <= 1'b1;
               if (byte_idx == 2'd3) begin
                  byte_idx      <= 2'd0;
                  user_req_addr <= user_req_addr + 21'd1;
                  if (last_word) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     state <= REQ;
                     req   <= 1'b1;
                  end
               end else begin
                  byte_idx <= nxt_idx;
               end
            end
            DONE: begin
               state         <= IDLE;
               busy          <= 1'b0;
               col_cnt       <= '0;
               row_cnt       <= '0;
               last_word     <= 1'b0;
               user_req_addr <= BASE_ADDR;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Directed bench for window_fetch_ctrl: small 8x3 frame, stray start/rd_valid, mid-unpack reset.
module tb_window_fetch_ctrl;
   localparam int          W          = 8;
   localparam int          L          = 8;
   localparam int          ROWS       = 2;
   localparam int          FRAME_ROWS = 3;
   localparam logic [20:0] BASE       = 21'h10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] user_rd_data;
   logic        rd_valid;
   logic        req, rd_wr, buf_we, window_valid, busy, frame_done, err;
   logic [20:0] user_req_addr;
   logic [W-1:0] buf_data;

   window_fetch_ctrl #(.W(W), .L(L), .ROWS(ROWS), .FRAME_ROWS(FRAME_ROWS), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .user_rd_data(user_rd_data), .rd_valid(rd_valid),
      .req(req), .rd_wr(rd_wr), .user_req_addr(user_req_addr), .buf_we(buf_we), .buf_data(buf_data),
      .window_valid(window_valid), .busy(busy), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // memory model: answers each req two cycles later with 0x44332211 + k*0x01010101
   logic        mem_en = 1'b0, mem_valid = 1'b0, man_valid = 1'b0;
   logic [31:0] mem_word = '0, man_word = '0;
   logic [2:0]  sh = '0;
   int          n_resp = 0;
   assign rd_valid     = mem_valid | man_valid;
   assign user_rd_data = mem_valid ? mem_word : man_word;

   always @(negedge clk) begin
      sh = {sh[1:0], mem_en & req};
      mem_valid = sh[2];
      if (sh[2]) begin
         mem_word = 32'h44332211 + 32'h01010101 * n_resp;
         n_resp++;
      end
   end

   // cycle index k holds during cycle k; rd_valid logged at the closing edge
   int cyc = 0;
   int n_rv = 0;
   int rv_cyc[64];
   always @(posedge clk) begin
      if (rd_valid === 1'b1 && n_rv < 64) begin
         rv_cyc[n_rv] = cyc;
         n_rv++;
      end
      cyc++;
   end

   int          n_req = 0, n_we = 0, n_done = 0;
   logic [20:0] addr_log[64];
   int          req_cyc[64];
   logic [7:0]  pix_log[128];
   logic        wv_log[128];
   int          we_cyc[128];
   always @(negedge clk) begin
      if (req === 1'b1) begin
         if (n_req < 64) begin addr_log[n_req] = user_req_addr; req_cyc[n_req] = cyc; end
         n_req++;
      end
      if (buf_we === 1'b1) begin
         if (n_we < 128) begin pix_log[n_we] = buf_data; wv_log[n_we] = window_valid; we_cyc[n_we] = cyc; end
         n_we++;
      end
      if (frame_done === 1'b1) n_done++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int   b_req, b_we, b_done, b_rv, t0;
   logic got;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_rd_wr", {31'd0, rd_wr}, 32'd0);
      chk("rst_addr", {11'd0, user_req_addr}, 32'h10);
      chk("rst_we", {31'd0, buf_we}, 32'd0);
      chk("rst_data", {24'd0, buf_data}, 32'd0);
      chk("rst_wv", {31'd0, window_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, frame_done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      reset = 1'b0;

      // rd_valid while idle is ignored
      @(negedge clk);
      man_word = 32'hFFFFFFFF; man_valid = 1'b1;
      @(negedge clk);
      man_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_rv_we", 32'(n_we), 32'd0);
      chk("idle_rv_busy", {31'd0, busy}, 32'd0);
      chk("idle_rv_req", 32'(n_req), 32'd0);

      // full frame
      b_req = n_req; b_we = n_we; b_done = n_done; b_rv = n_rv;
      mem_en = 1'b1;
      start = 1'b1; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", {31'd0, busy}, 32'd1);
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) got = 1'b1;
      end
      chk("frame_done_seen", {31'd0, got}, 32'd1);
      @(negedge clk);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("addr_after_done", {11'd0, user_req_addr}, 32'h10);
      mem_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("n_req", 32'(n_req - b_req), 32'd6);
      chk("n_we", 32'(n_we - b_we), 32'd24);
      chk("n_done", 32'(n_done - b_done), 32'd1);
      chk("start_to_req", 32'(req_cyc[b_req] - t0), 32'd1);
      chk("rv_to_we0", 32'(we_cyc[b_we] - rv_cyc[b_rv]), 32'd1);
      chk("rv_to_we3", 32'(we_cyc[b_we + 3] - rv_cyc[b_rv]), 32'd4);
      chk("rv_to_req", 32'(req_cyc[b_req + 1] - rv_cyc[b_rv]), 32'd5);
      for (int k = 0; k < 6; k++)
         chk($sformatf("addr%0d", k), {11'd0, addr_log[b_req + k]}, 32'h10 + 32'(k));
      for (int p = 0; p < 24; p++) begin
         chk($sformatf("pix%0d", p), {24'd0, pix_log[b_we + p]}, 32'h11 * 32'((p % 4) + 1) + 32'(p / 4));
         chk($sformatf("wv%0d", p), {31'd0, wv_log[b_we + p]}, (p >= 8) ? 32'd1 : 32'd0);
      end

      // stray start in WAIT_DATA, no response for a long time, then reset mid-unpack
      b_req = n_req; b_we = n_we; b_done = n_done;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("req2_pulse", {31'd0, req}, 32'd1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      chk("wait_one_req", 32'(n_req - b_req), 32'd1);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      chk("wait_err", {31'd0, err}, 32'd0);
      chk("wait_no_we", 32'(n_we - b_we), 32'd0);
      man_word = 32'hDDCCBBAA; man_valid = 1'b1;
      @(negedge clk);
      man_valid = 1'b0;
      chk("rst_test_b0", {24'd0, buf_data}, 32'hAA);
      @(negedge clk);
      @(negedge clk);
      chk("rst_test_b2", {24'd0, buf_data}, 32'hCC);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_we", {31'd0, buf_we}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_addr", {11'd0, user_req_addr}, 32'h10);
      chk("mid_rst_we_cnt", 32'(n_we - b_we), 32'd3);
      repeat (3) @(negedge clk);
      chk("mid_rst_no_done", 32'(n_done - b_done), 32'd0);
      chk("mid_rst_no_req", 32'(n_req - b_req), 32'd1);

      // refetch starts again at the base address
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("refetch_req", {31'd0, req}, 32'd1);
      chk("refetch_addr", {11'd0, user_req_addr}, 32'h10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
